// File: rtl/bcd_counter_disp.sv
// bcd_counter_disp
//   Multi-digit BCD up/down counter with tick prescaler, synchronous BCD load,
//   terminal-count pulse and time-multiplexed active-low 7-segment drive.
//
// Parameters
//   DIGITS   : number of BCD digits (1..8)
//   TICK_DIV : clk cycles per count tick (>=1, 1 = every cycle)
//   SCAN_DIV : clk cycles each digit stays selected during display scan (>=1)
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   en       : count enable, only meaningful on tick cycles
//   up_down  : 1 = count up, 0 = count down
//   load     : synchronous load strobe (priority over counting)
//   data_in  : BCD load value, nibble k = digit k
//   count    : registered BCD count
//   tc       : one-cycle pulse after a decimal wrap
//   load_err : one-cycle pulse after a rejected (non-BCD) load
//   disp_out : segments a..g ([0:6]), active low, for the selected digit
//   an       : active-low one-hot digit enable
module bcd_counter_disp #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err,
  output logic [0:6]            disp_out,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  logic [PW-1:0]       presc;
  logic [PW-1:0]       presc_run;
  logic                tick;
  logic                load_ok;
  logic [4*DIGITS-1:0] cnt_next;
  logic                wrap;
  logic [3:0]          dig;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       scan_idx;
  logic [3:0]          nib;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign presc_run = tick ? '0 : presc + PW'(1);

  // Load is accepted only if every nibble is a legal BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (data_in[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple carry/borrow: the carry-in of digit 0 is always set, and the
  // carry that falls out of the top digit is the decimal wrap.
  always_comb begin
    cnt_next = count;
    wrap     = 1'b1;
    dig      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (wrap) begin
        if (up_down) begin
          if (dig >= 4'd9) dig = 4'd0;
          else begin
            dig  = dig + 4'd1;
            wrap = 1'b0;
          end
        end else begin
          if (dig == 4'd0) dig = 4'd9;
          else begin
            dig  = dig - 4'd1;
            wrap = 1'b0;
          end
        end
      end
      cnt_next[4*i +: 4] = dig;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      presc    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // A rejected load leaves the prescaler running so tick cadence holds;
        // a coincident tick is dropped either way.
        if (load_ok) begin
          count <= data_in;
          presc <= '0;
        end else begin
          load_err <= 1'b1;
          presc    <= presc_run;
        end
      end else begin
        presc <= presc_run;
        if (tick && en) begin
          count <= cnt_next;
          tc    <= wrap;
        end
      end
    end
  end

  // Display scan: index advances each time the scan counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) nib = count[4*i +: 4];
    end
  end

  assign an = ~(DIGITS'(1) << scan_idx);

  always_comb begin
    case (nib)
      4'd0:    disp_out = 7'b0000001;
      4'd1:    disp_out = 7'b1001111;
      4'd2:    disp_out = 7'b0010010;
      4'd3:    disp_out = 7'b0000110;
      4'd4:    disp_out = 7'b1001100;
      4'd5:    disp_out = 7'b0100100;
      4'd6:    disp_out = 7'b0100000;
      4'd7:    disp_out = 7'b0001111;
      4'd8:    disp_out = 7'b0000000;
      4'd9:    disp_out = 7'b0000100;
      default: disp_out = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_bcd_counter_disp.sv
// Directed bench for bcd_counter_disp with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_counter_disp;

  logic       clk = 1'b0;
  logic       rst, en, up_down, load;
  logic [7:0] data_in;
  logic [7:0] count;
  logic       tc, load_err;
  logic [0:6] disp_out;
  logic [1:0] an;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bcd_counter_disp #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
    .data_in(data_in), .count(count), .tc(tc), .load_err(load_err),
    .disp_out(disp_out), .an(an)
  );

  typedef struct {
    logic       rst, load, en, ud;
    logic [7:0] data;
    logic [7:0] exp_count;
    logic       exp_tc, exp_le;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic ld, input logic [7:0] d,
                     input logic e, input logic ud, input logic [7:0] c,
                     input logic t, input logic le);
    vec_t v;
    v.rst = r; v.load = ld; v.data = d; v.en = e; v.ud = ud;
    v.exp_count = c; v.exp_tc = t; v.exp_le = le;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] pat [10];
  logic [6:0] dv;
  logic [7:0] e;
  int n, idx;

  initial begin
    pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
    pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
    pat[6] = 7'b0100000; pat[7] = 7'b0001111; pat[8] = 7'b0000000;
    pat[9] = 7'b0000100;

    //   n  rst ld data  en ud  count tc le
    add(1, 1, 0, 8'h00, 0, 1, 8'h00, 0, 0);
    // load 98, count up through wrap
    add(1, 0, 1, 8'h98, 1, 1, 8'h98, 0, 0);
    add(3, 0, 0, 8'h00, 1, 1, 8'h98, 0, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h99, 0, 0);
    add(3, 0, 0, 8'h00, 1, 1, 8'h99, 0, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h00, 1, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    // load 00, count down through wrap, then hold with en=0
    add(1, 0, 1, 8'h00, 1, 0, 8'h00, 0, 0);
    add(3, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h99, 1, 0);
    add(3, 0, 0, 8'h00, 1, 0, 8'h99, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h98, 0, 0);
    add(8, 0, 0, 8'h00, 0, 0, 8'h98, 0, 0);
    add(3, 0, 0, 8'h00, 1, 0, 8'h98, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h97, 0, 0);
    // rejected load 3A keeps count and cadence
    add(1, 0, 1, 8'h3A, 1, 0, 8'h97, 0, 1);
    add(2, 0, 0, 8'h00, 1, 0, 8'h97, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h96, 0, 0);
    // load 42 on a tick cycle: no increment, cadence restarts
    add(3, 0, 0, 8'h00, 1, 1, 8'h96, 0, 0);
    add(1, 0, 1, 8'h42, 1, 1, 8'h42, 0, 0);
    add(3, 0, 0, 8'h00, 1, 1, 8'h42, 0, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h43, 0, 0);
    // high nibble invalid, then 99 valid boundary
    add(1, 0, 1, 8'hA0, 1, 1, 8'h43, 0, 1);
    add(1, 0, 1, 8'h99, 1, 1, 8'h99, 0, 0);
    add(3, 0, 0, 8'h00, 1, 1, 8'h99, 0, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h00, 1, 0);
    // rst beats load and a would-be down wrap; no tc emitted
    add(3, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add(1, 1, 1, 8'h55, 1, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    // rejected load on a tick cycle drops that tick, cadence unchanged
    add(2, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    add(1, 0, 1, 8'hF0, 1, 1, 8'h00, 0, 1);
    add(3, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h01, 0, 0);

    rst = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; data_in = '0;
    step();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; load = vecs[i].load; data_in = vecs[i].data;
      en = vecs[i].en; up_down = vecs[i].ud;
      step();
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      chk($sformatf("vec%0d load_err", i), 32'(load_err), 32'(vecs[i].exp_le));
    end

    // Reset then count up 40 cycles: one increment every 4 cycles, decimal carry
    rst = 1'b1; load = 1'b0; en = 1'b1; up_down = 1'b1; data_in = '0;
    step();
    dv = disp_out;
    chk("reset count", 32'(count), 32'h00);
    chk("reset an", 32'(an), 32'b10);
    chk("reset disp", 32'(dv), 32'b0000001);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      n = k / 4;
      e[7:4] = 4'(n / 10);
      e[3:0] = 4'(n % 10);
      chk($sformatf("upcount k=%0d", k), 32'(count), 32'(e));
    end
    // reset mid-count
    rst = 1'b1;
    step();
    chk("midcount rst count", 32'(count), 32'h00);
    chk("midcount rst tc", 32'(tc), 32'h0);

    // Scan with count 57 held (en=0)
    en = 1'b0;
    step();
    rst = 1'b0; load = 1'b1; data_in = 8'h57;
    step();
    load = 1'b0; data_in = '0;
    chk("scan count", 32'(count), 32'h57);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) step();
      idx = (k / 2) % 2;
      dv = disp_out;
      chk($sformatf("scan an k=%0d", k), 32'(an), (idx == 1) ? 32'b01 : 32'b10);
      chk($sformatf("scan disp k=%0d", k), 32'(dv),
          (idx == 1) ? 32'b0100100 : 32'b0001111);
    end
    // reset while digit 1 is selected
    rst = 1'b1;
    step();
    rst = 1'b0;
    dv = disp_out;
    chk("midscan rst an", 32'(an), 32'b10);
    chk("midscan rst disp", 32'(dv), 32'b0000001);

    // Decoder sweep: both digits equal so either scan index shows the same code
    for (int d = 0; d < 10; d++) begin
      load = 1'b1; data_in = {4'(d), 4'(d)};
      step();
      dv = disp_out;
      chk($sformatf("seg digit %0d", d), 32'(dv), 32'(pat[d]));
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
